pcie_dll_tx_replay: RTL and testbench

- Transmit-side data link layer stage, sitting directly downstream of the transaction-layer TLP packer and upstream of the physical-layer framer.
- Takes 224-bit TLPs ({fmt,type,tc,length,requestID,addr,payload} layout), prepends a 12-bit sequence number and appends a 32-bit LCRC.
- Keeps every sent packet in a replay buffer until it is ACKed.
- Replays the buffered packets on a NAK or on replay-timer expiry.

---
 rtl/pcie_dll_tx_replay_if.sv | 42 ++++
 rtl/pcie_dll_tx_replay.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pcie_dll_tx_replay.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_dll_tx_replay_if.sv
// ---------------------------------------------------------------------------
// pcie_dll_tx_replay_if
//
// Bundles the three handshake channels of the transmit-side data link
// replay stage:
//   tlp_*  : TLPs arriving from the transaction-layer packer
//   pkt_*  : framed packets {4'b0, seq, tlp, lcrc} going to the PHY framer
//   ack_*  : ACK/NAK DLLPs returned by the link partner
//
// Handshake rule for every channel: a transfer happens on a rising clock
// edge where both valid and ready are high. The source holds valid and
// its data stable until that edge; ready may change freely while valid is
// low and never depends combinationally on valid.
//
// Modports:
//   slave  : the replay stage itself (consumes tlp/ack, produces pkt)
//   master : the environment around it (produces tlp/ack, consumes pkt)
// ---------------------------------------------------------------------------
interface pcie_dll_tx_replay_if;
  logic         tlp_valid;
  logic         tlp_ready;
  logic [223:0] tlp;

  logic         pkt_valid;
  logic         pkt_ready;
  logic [271:0] pkt;

  logic         ack_valid;
  logic         ack_ready;
  logic         ack_nak;
  logic [11:0]  ack_seq;

  modport slave (
    input  tlp_valid, tlp, pkt_ready, ack_valid, ack_nak, ack_seq,
    output tlp_ready, pkt_valid, pkt, ack_ready
  );

  modport master (
    output tlp_valid, tlp, pkt_ready, ack_valid, ack_nak, ack_seq,
    input  tlp_ready, pkt_valid, pkt, ack_ready
  );
endinterface

// File: rtl/pcie_dll_tx_replay.sv
// ---------------------------------------------------------------------------
// pcie_dll_tx_replay
//
// Transmit-side data link layer stage. Each accepted 224-bit TLP gets a
// 12-bit sequence number prepended and a 32-bit LCRC appended, is sent
// through a one-deep output register, and is kept in a replay buffer until
// the link partner ACKs it. A NAK or a replay-timer expiry re-sends every
// unacknowledged packet, oldest first, bit-identical to the original.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, asserted when HIGH
//   bus          tlp/pkt/ack handshake channels (slave modport)
//   occupancy    number of unacknowledged packets held in the buffer
//   next_seq     NEXT_TRANSMIT_SEQ
//   ackd_seq     ACKD_SEQ (sequence number of the last acknowledged packet)
//   retrain      1-cycle pulse when the replay counter rolls over
//   dllp_err     1-cycle pulse when an ACK/NAK names an unsent sequence
//   replay_state FSM state: 0 = NORMAL, 1 = REPLAY
// ---------------------------------------------------------------------------
module pcie_dll_tx_replay #(
  parameter int DEPTH          = 4,
  parameter int REPLAY_TIMEOUT = 64,
  parameter int CW             = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pcie_dll_tx_replay_if.slave   bus,
  output logic [CW-1:0]         occupancy,
  output logic [11:0]           next_seq,
  output logic [11:0]           ackd_seq,
  output logic                  retrain,
  output logic                  dllp_err,
  output logic                  replay_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REPLAY_TIMEOUT - 1);
  localparam logic [31:0]   CRC_POLY   = 32'h04C11DB7;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  state_t state, state_next;

  // Replay storage and bookkeeping
  logic [271:0]  buf_mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] replay_idx;
  logic [CW-1:0] replay_left;
  logic [1:0]    replay_num;
  logic [TW-1:0] timer;

  // Output register
  logic          pkt_valid_q;
  logic [271:0]  pkt_q;

  // Combinational control
  logic          out_free;
  logic          tlp_ready_c;
  logic          ack_ready_c;
  logic          replay_load;
  logic          tlp_fire;
  logic          ack_fire;
  logic          ack_ok;
  logic          ack_bad;
  logic          ack_dup;
  logic          nak_go;
  logic          timeout;
  logic          start_replay;
  logic [11:0]   seq_diff;
  logic [CW-1:0] purge_cnt;
  logic [CW-1:0] occ_next;
  logic [AW-1:0] rptr_next;
  logic [1:0]    replay_num_base;
  logic [31:0]   lcrc;
  logic [271:0]  framed;

  // CRC-32 over {4'b0, seq, tlp}, MSB first, seeded with all ones,
  // result inverted. Pure feed-forward loop, unrolls into an XOR tree.
  function automatic logic [31:0] lcrc32(input logic [239:0] data);
    logic [31:0] crc;
    logic        fb;
    crc = 32'hFFFFFFFF;
    for (int i = 239; i >= 0; i--) begin
      fb  = crc[31] ^ data[i];
      crc = {crc[30:0], 1'b0};
      if (fb) begin
        crc = crc ^ CRC_POLY;
      end
    end
    return ~crc;
  endfunction

  // The output register can take a new packet when it is empty or its
  // current packet leaves this cycle.
  assign out_free = !pkt_valid_q || bus.pkt_ready;

  // ---------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= ST_NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 3: state-dependent outputs
  // ---------------------------------------------------------------------
  always_comb begin
    tlp_ready_c = 1'b0;
    ack_ready_c = 1'b0;
    replay_load = 1'b0;
    case (state)
      ST_NORMAL: begin
        tlp_ready_c = out_free && (occupancy < DEPTH_C);
        ack_ready_c = 1'b1;
      end
      ST_REPLAY: begin
        replay_load = out_free;
      end
      default: begin
        tlp_ready_c = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // ACK/NAK evaluation, occupancy arithmetic and framing
  // ---------------------------------------------------------------------
  always_comb begin
    tlp_fire = bus.tlp_valid && tlp_ready_c;
    ack_fire = bus.ack_valid && ack_ready_c;

    // Modular distance from the last ACKed sequence; the 12-bit
    // subtraction absorbs the 4095 -> 0 wrap.
    seq_diff = bus.ack_seq - ackd_seq;
    ack_dup  = ack_fire && (seq_diff == 12'd0);
    ack_ok   = ack_fire && (seq_diff != 12'd0) && (seq_diff <= 12'(occupancy));
    ack_bad  = ack_fire && (seq_diff > 12'(occupancy));

    // d is bounded by occupancy here, so truncation to CW bits is exact.
    purge_cnt = ack_ok ? CW'(seq_diff) : '0;
    rptr_next = rptr + AW'(purge_cnt);

    // d is judged against the pre-accept occupancy; both effects apply.
    occ_next = occupancy + CW'(tlp_fire) - purge_cnt;

    nak_go = (ack_ok || ack_dup) && bus.ack_nak;

    // A purge in the same cycle restarts the timer instead of expiring it.
    timeout = (state == ST_NORMAL) && (occupancy != '0) && !ack_ok &&
              (timer == TIMER_LAST);

    // A purge zeroes the replay counter before any replay it triggers.
    replay_num_base = ack_ok ? 2'd0 : replay_num;

    lcrc   = lcrc32({4'b0000, next_seq, bus.tlp});
    framed = {4'b0000, next_seq, bus.tlp, lcrc};
  end

  // ---------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    start_replay = 1'b0;
    case (state)
      ST_NORMAL: begin
        // NAK and timer expiry together still produce a single replay.
        if ((nak_go && (occ_next != '0)) || timeout) begin
          state_next   = ST_REPLAY;
          start_replay = 1'b1;
        end
      end
      ST_REPLAY: begin
        if (replay_load && (replay_left == CW'(1))) begin
          state_next = ST_NORMAL;
        end
      end
      default: begin
        state_next = ST_NORMAL;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pkt_valid_q <= 1'b0;
      pkt_q       <= '0;
      next_seq    <= 12'd0;
      ackd_seq    <= 12'hFFF;
      occupancy   <= '0;
      wptr        <= '0;
      rptr        <= '0;
      replay_idx  <= '0;
      replay_left <= '0;
      replay_num  <= 2'd0;
      timer       <= '0;
      retrain     <= 1'b0;
      dllp_err    <= 1'b0;
    end else begin
      retrain   <= 1'b0;
      dllp_err  <= ack_bad;
      occupancy <= occ_next;

      if (tlp_fire) begin
        pkt_q       <= framed;
        pkt_valid_q <= 1'b1;
        next_seq    <= next_seq + 12'd1;
        wptr        <= wptr + AW'(1);
      end else if (replay_load) begin
        // Stored frames already carry their original seq and LCRC.
        pkt_q       <= buf_mem[replay_idx];
        pkt_valid_q <= 1'b1;
        replay_idx  <= replay_idx + AW'(1);
        replay_left <= replay_left - CW'(1);
      end else if (bus.pkt_ready) begin
        pkt_valid_q <= 1'b0;
      end

      if (ack_ok) begin
        rptr     <= rptr_next;
        ackd_seq <= bus.ack_seq;
      end

      if (start_replay) begin
        replay_idx  <= rptr_next;
        replay_left <= occ_next;
        replay_num  <= replay_num_base + 2'd1;
        retrain     <= (replay_num_base == 2'd3);
      end else begin
        replay_num  <= replay_num_base;
      end

      // Counts only while NORMAL with something outstanding and no purge.
      if ((state == ST_NORMAL) && (occupancy != '0) && !ack_ok && !start_replay) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end
    end
  end

  // Buffer array holds no reset: reset empties it by clearing the pointers
  // and occupancy, so stale contents are never read back.
  always_ff @(posedge clk) begin
    if (tlp_fire) begin
      buf_mem[wptr] <= framed;
    end
  end

  assign bus.tlp_ready = tlp_ready_c;
  assign bus.ack_ready = ack_ready_c;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt       = pkt_q;
  assign replay_state  = (state == ST_REPLAY);

endmodule

// File: tb/tb_pcie_dll_tx_replay.sv
// ---------------------------------------------------------------------------
// tb_pcie_dll_tx_replay
//
// Directed bench for pcie_dll_tx_replay (DEPTH=4, REPLAY_TIMEOUT=64).
// Stimulus tasks push every packet the DUT should emit (originals and
// replays) into exp_q; a negedge monitor pops and compares whenever a
// packet transfer is presented. The LCRC reference uses the augmented
// (message-plus-32-zero-bits) long-division form with the seed folded into
// the leading bits.
// ---------------------------------------------------------------------------
module tb_pcie_dll_tx_replay;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pcie_dll_tx_replay_if bus();

  logic [CW-1:0] occupancy;
  logic [11:0]   next_seq;
  logic [11:0]   ackd_seq;
  logic          retrain;
  logic          dllp_err;
  logic          replay_state;

  pcie_dll_tx_replay #(
    .DEPTH(DEPTH),
    .REPLAY_TIMEOUT(64),
    .CW(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .occupancy(occupancy),
    .next_seq(next_seq),
    .ackd_seq(ackd_seq),
    .retrain(retrain),
    .dllp_err(dllp_err),
    .replay_state(replay_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state and model
  // -------------------------------------------------------------------------
  int           checks = 0;
  int           errors = 0;
  logic [271:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [271:0] sent_q[$];
  logic [11:0]  m_seq;
  logic [11:0]  m_ackd;
  logic [271:0] mon_e;
  int           mon_c;

  function automatic logic [31:0] ref_lcrc(input logic [239:0] data);
    logic [271:0] m;
    logic [31:0]  r;
    logic         top;
    m = {data, 32'h0};
    m[271:240] = m[271:240] ^ 32'hFFFFFFFF;
    r = 32'h0;
    for (int i = 271; i >= 0; i--) begin
      top = r[31];
      r   = {r[30:0], m[i]};
      if (top) r = r ^ 32'h04C11DB7;
    end
    return ~r;
  endfunction

  function automatic logic [223:0] mk_tlp(input int n);
    return {3'b010, 5'b00000, 3'(n % 8), 10'(n), 16'h0100,
            32'hDEAD0000 | 32'(n), 32'h0000_1000,
            59'h0, 32'(n * 7), 32'hCAFEF00D};
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    sent_q.delete();
    m_seq  = 12'd0;
    m_ackd = 12'hFFF;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
  endtask

  // timed=1: packet must appear exactly one cycle after acceptance.
  task automatic send_tlp(input logic [223:0] t, input bit timed);
    int n;
    logic [271:0] p;
    n = 0;
    bus.tlp       = t;
    bus.tlp_valid = 1'b1;
    @(negedge clk);
    while (!bus.tlp_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tlp_ready) begin
      fail("tlp_accept");
      bus.tlp_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.tlp_valid = 1'b0;
    p = {4'b0000, m_seq, t, ref_lcrc({4'b0000, m_seq, t})};
    exp_q.push_back(p);
    exp_cyc_q.push_back(timed ? cyc : -1);
    sent_q.push_back(p);
    m_seq = m_seq + 12'd1;
  endtask

  task automatic push_replay();
    foreach (sent_q[i]) begin
      exp_q.push_back(sent_q[i]);
      exp_cyc_q.push_back(-1);
    end
  endtask

  task automatic send_ack(input logic nak, input logic [11:0] seq);
    int n;
    int d;
    bit ok;
    n = 0;
    bus.ack_valid = 1'b1;
    bus.ack_nak   = nak;
    bus.ack_seq   = seq;
    @(negedge clk);
    while (!bus.ack_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ack_ready) begin
      fail("ack_accept");
      bus.ack_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.ack_valid = 1'b0;
    d  = int'(12'(seq - m_ackd));
    ok = (d != 0) && (d <= sent_q.size());
    if (ok) begin
      repeat (d) void'(sent_q.pop_front());
      m_ackd = seq;
    end
    if (nak && (ok || d == 0) && sent_q.size() > 0) push_replay();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      fail(name);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor: compares each presented packet transfer against exp_q
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n && bus.pkt_valid && bus.pkt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pkt_unexpected: got seq %0h lcrc %0h, expected no packet",
                 bus.pkt[267:256], bus.pkt[31:0]);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (bus.pkt !== mon_e) begin
          errors++;
          $display("FAIL pkt_data: got %h expected %h", bus.pkt, mon_e);
        end else if (mon_c >= 0 && mon_c != cyc) begin
          errors++;
          $display("FAIL pkt_latency: seq %0h got cycle %0d expected %0d",
                   bus.pkt[267:256], cyc, mon_c);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Directed tests
  // -------------------------------------------------------------------------
  initial begin
    int n;
    int t0;
    bus.tlp_valid = 1'b0;
    bus.tlp       = '0;
    bus.pkt_ready = 1'b1;
    bus.ack_valid = 1'b0;
    bus.ack_nak   = 1'b0;
    bus.ack_seq   = '0;
    m_seq  = 12'd0;
    m_ackd = 12'hFFF;

    // Reset values
    repeat (2) tick();
    check("rst_pkt_valid", bus.pkt_valid, 1'b0);
    check("rst_pkt_zero", (bus.pkt == '0), 1'b1);
    check("rst_next_seq", next_seq, 12'd0);
    check("rst_ackd_seq", ackd_seq, 12'hFFF);
    check("rst_occupancy", occupancy, 3'd0);
    check("rst_retrain", retrain, 1'b0);
    check("rst_dllp_err", dllp_err, 1'b0);
    check("rst_state", replay_state, 1'b0);

    // 1: three back-to-back TLPs, then output-register backpressure
    do_reset();
    for (int i = 0; i < 3; i++) send_tlp(mk_tlp(i + 1), 1'b1);
    check("t1_occupancy", occupancy, 3'd3);
    check("t1_next_seq", next_seq, 12'd3);
    wait_drain("t1_drain");
    bus.pkt_ready = 1'b0;
    send_tlp(mk_tlp(9), 1'b0);
    check("t1_bp_tlp_ready", bus.tlp_ready, 1'b0);
    repeat (3) tick();
    check("t1_bp_hold_valid", bus.pkt_valid, 1'b1);
    check("t1_bp_hold_seq", bus.pkt[267:256], 12'd3);
    bus.pkt_ready = 1'b1;
    wait_drain("t1_bp_drain");

    // 2: full buffer, then ACK frees two entries
    do_reset();
    for (int i = 0; i < 4; i++) send_tlp(mk_tlp(20 + i), 1'b1);
    check("t2_full_occ", occupancy, 3'd4);
    check("t2_full_ready", bus.tlp_ready, 1'b0);
    send_ack(1'b0, 12'd1);
    check("t2_ack_occ", occupancy, 3'd2);
    check("t2_ack_ackd", ackd_seq, 12'd1);
    check("t2_ack_ready", bus.tlp_ready, 1'b1);
    wait_drain("t2_drain");

    // 3: NAK seq 0 purges seq 0 and replays seq 1, 2
    do_reset();
    for (int i = 0; i < 3; i++) send_tlp(mk_tlp(30 + i), 1'b1);
    send_ack(1'b1, 12'd0);
    check("t3_state_replay", replay_state, 1'b1);
    check("t3_ack_ready_low", bus.ack_ready, 1'b0);
    check("t3_tlp_ready_low", bus.tlp_ready, 1'b0);
    tick();
    check("t3_ack_ready_low2", bus.ack_ready, 1'b0);
    wait_drain("t3_drain");
    check("t3_state_normal", replay_state, 1'b0);
    check("t3_occupancy", occupancy, 3'd2);
    check("t3_next_seq", next_seq, 12'd3);
    check("t3_ackd", ackd_seq, 12'd0);

    // 4: replay timer, four replays, retrain on the fourth; reset mid-replay
    do_reset();
    send_tlp(mk_tlp(40), 1'b1);
    t0 = cyc;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (replay_state == 1'b0 && n < 300) begin
        tick();
        n++;
      end
      if (replay_state == 1'b0) begin
        fail($sformatf("t4_replay_%0d", r));
        break;
      end
      if (r == 0) check("t4_timeout_gap", cyc - t0, 64);
      check($sformatf("t4_retrain_%0d", r), retrain, (r == 3));
      if (r < 3) begin
        push_replay();
        n = 0;
        while (replay_state == 1'b1 && n < 20) begin
          tick();
          n++;
        end
      end
    end
    rst_n = 1'b1;
    #1;
    check("t4_rst_occ", occupancy, 3'd0);
    check("t4_rst_valid", bus.pkt_valid, 1'b0);
    check("t4_rst_state", replay_state, 1'b0);
    do_reset();
    repeat (10) tick();
    check("t4_no_stale_pkt", bus.pkt_valid, 1'b0);

    // 5: out-of-range ACK
    do_reset();
    for (int i = 0; i < 2; i++) send_tlp(mk_tlp(50 + i), 1'b1);
    send_ack(1'b0, 12'd7);
    check("t5_dllp_err", dllp_err, 1'b1);
    check("t5_occ", occupancy, 3'd2);
    check("t5_ackd", ackd_seq, 12'hFFF);
    tick();
    check("t5_dllp_err_pulse", dllp_err, 1'b0);
    wait_drain("t5_drain");

    // 6: sequence wrap 4094, 4095, 0
    do_reset();
    for (int i = 0; i < 4094; i++) begin
      send_tlp(mk_tlp(i), 1'b1);
      send_ack(1'b0, m_seq - 12'd1);
    end
    check("t6_pre_next", next_seq, 12'd4094);
    check("t6_pre_ackd", ackd_seq, 12'd4093);
    for (int i = 0; i < 3; i++) send_tlp(mk_tlp(60 + i), 1'b1);
    check("t6_wrap_next", next_seq, 12'd1);
    check("t6_wrap_occ", occupancy, 3'd3);
    send_ack(1'b0, 12'd0);
    check("t6_purge_occ", occupancy, 3'd0);
    check("t6_purge_ackd", ackd_seq, 12'd0);
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
